life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Parametrised cellular-automaton core for the VGA Game of Life designs.
- Board is 2**LOG_W x 2**LOG_H cells and double-buffered: two banks, front and back. The video path reads the front bank combinationally. The engine computes the next generation into the back bank.
- Banks swap only during a frame-sync window, so the display never tears. This removes the old copy phase.
- Birth/survive rule masks and edge mode (torus or dead border) are runtime inputs, so Life, HighLife and other B/S rules run without rebuilding.

Parameters:
- LOG_W, 5, log2 board width (columns)
- LOG_H, 4, log2 board height (rows)
- LFSR_SEED, 16'hACE1, reset value of the 16-bit seeding LFSR; must be non-zero

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- step_req  in  1  request one generation; sampled in IDLE only
- seed_req  in  1  request random reseed; sampled in IDLE only
- birth_mask  in  9  bit n=1: dead cell with n live neighbours is born
- survive_mask  in  9  bit n=1: live cell with n live neighbours survives
- wrap_en  in  1  1 = toroidal edges, 0 = out-of-board neighbours read as dead
- frame_sync  in  1  level; high while a bank swap is allowed (vsync/blanking)
- rd_x  in  LOG_W  display read column
- rd_y  in  LOG_H  display read row
- rd_cell  out  1  front-bank cell at (rd_x, rd_y); combinational, zero latency
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on the cycle after a swap
- generation  out  16  generation count
- pop_count  out  LOG_W+LOG_H+1  live cells in front bank (see Optional Feature)

Behaviour:
- Cell index is {y, x}, with x in the low LOG_W bits; N = 2**(LOG_W+LOG_H).
- States: SEED, IDLE, STEP, WAIT_SYNC.

Reset and startup:
- Reset values: state=SEED, front=bank0, busy=1, done=0, generation=0, pop_count=0, lfsr=LFSR_SEED, all indices 0.
- Bank RAM contents are not reset.
- After reset release, the engine seeds automatically, like the boot sequence.
- Reset asserted mid-operation aborts immediately to the reset values. Partially written bank data is discarded by the subsequent reseed.

LFSR:
- Shifts left every clock in every state.
- Feedback bit = b15^b13^b12^b10; it enters at bit 0.

SEED:
- Writes back[idx] <= lfsr[0] for idx = 0..N-1, one cell per cycle: N cycles.
- Then enters WAIT_SYNC with a seed flag set.

IDLE:
- seed_req has priority over step_req when both are high in the same cycle.
- Accepted request: busy rises on the next cycle.
- wrap_en, birth_mask and survive_mask are latched at step accept and held for the whole step.
- Requests while busy are ignored and not queued.

STEP, per cell (9 cycles):
- Cycles 0..7: accumulate neighbours into a 4-bit count, in order (-1,+1)(0,+1)(+1,+1)(-1,0)(+1,0)(-1,-1)(0,-1)(+1,-1), all reads from the front bank.
- Wrap mode: coordinates are taken mod width/height.
- Dead-border mode: a coordinate outside 0..W-1 or 0..H-1 contributes 0. Underflow must be detected, not masked.
- Cycle 8 writes back[idx] <= front[idx] ? survive_mask[cnt] : birth_mask[cnt], then advances idx.
- Total step length is 9*N cycles, then WAIT_SYNC.

WAIT_SYNC:
- On the first clock edge with frame_sync=1: front <= ~front, state <= IDLE, done=1 for one cycle.
- The swap may fall on the same edge the state is entered if frame_sync is already high.
- generation: +1 on a step swap (wraps 16'hFFFF -> 0); set to 0 on a seed swap.
- frame_sync low indefinitely: the engine waits; rd_cell keeps showing the old front bank.

General:
- rd_cell always reflects the front bank and is unaffected by engine writes.

Optional Feature:
- Macro: LIFE_POPCOUNT_EN.
- Defined: a counter clears at SEED/STEP start and adds each written cell value. The total is transferred to pop_count on the swap edge, so pop_count always matches the front bank.
- Not defined: the counter is absent; pop_count is tied to 0, and the port remains.

Test Plan:
- Reset, LOG_W=LOG_H=3: busy=1, no done for 64 cycles. With frame_sync=1: done 1 cycle later, generation=0, and the front bank matches the reference LFSR stream from 16'hACE1 (cell0=1, since 16'hACE1 bit0=1).
- Blinker: B3/S23, wrap_en=1, 8x8, cells (3,2)(3,3)(3,4) set. One step -> (2,3)(3,3)(4,3) only. busy held exactly 576 cycles plus the sync wait. generation=1.
- Edge mode: glider heading off the right edge, 4 steps. wrap_en=1 -> reappears at x=0. wrap_en=0 -> edge cells die with no wrap ghosts; single cell at (0,0) with neighbours (7,7)(7,0)(0,7) -> survives only in wrap mode.
- Rule change: HighLife birth_mask=9'b001001000, survive_mask=9'b000001100. Isolated dead cell with 6 live neighbours -> born. Same stimulus under B3/S23 -> stays dead.
- Handshake: step_req and seed_req in the same IDLE cycle -> seed performed. step_req pulses during busy -> ignored, generation +1 only. frame_sync held low 1000 cycles after compute -> rd_cell unchanged and no done until frame_sync rises.
- Reset asserted mid-STEP -> busy stays 1, generation=0, new seed sequence restarts from LFSR_SEED. With LIFE_POPCOUNT_EN, blinker test -> pop_count=3 after each swap.

Source files
------------

// File: rtl/life_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : life_engine_if
//  Description : Control, rule and display-read bundle for life_engine.
//                The master side issues requests and reads cells; the
//                slave side is the engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface life_engine_if #(
  parameter int LOG_W = 5,
  parameter int LOG_H = 4
);
  logic                   step_req;
  logic                   seed_req;
  logic [8:0]             birth_mask;
  logic [8:0]             survive_mask;
  logic                   wrap_en;
  logic                   frame_sync;
  logic [LOG_W-1:0]       rd_x;
  logic [LOG_H-1:0]       rd_y;
  logic                   rd_cell;
  logic                   busy;
  logic                   done;
  logic [15:0]            generation;
  logic [LOG_W+LOG_H:0]   pop_count;

  modport master (
    output step_req, seed_req, birth_mask, survive_mask, wrap_en, frame_sync,
    output rd_x, rd_y,
    input  rd_cell, busy, done, generation, pop_count
  );

  modport slave (
    input  step_req, seed_req, birth_mask, survive_mask, wrap_en, frame_sync,
    input  rd_x, rd_y,
    output rd_cell, busy, done, generation, pop_count
  );
endinterface
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_engine
//  Description : Double-buffered Game-of-Life core. The display reads the
//                front bank combinationally while the next generation is
//                built in the back bank; banks swap only inside frame_sync.
//                Birth/survive masks and edge mode are runtime inputs.
//                Optional macro LIFE_POPCOUNT_EN adds the live-cell counter.
//  Revision    : 1.0  initial release
// ============================================================================
module life_engine #(
  parameter int          LOG_W     = 5,
  parameter int          LOG_H     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input wire            clk,
  input wire            rst_n,
  life_engine_if.slave  bus
);
  localparam int IW = LOG_W + LOG_H;
  localparam int N  = 1 << IW;

  typedef enum logic [1:0] {
    SEED      = 2'd0,
    IDLE      = 2'd1,
    STEP      = 2'd2,
    WAIT_SYNC = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            front_q, front_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      phase_q, phase_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     gen_q, gen_d;
  logic            seed_flag_q, seed_flag_d;
  logic            done_q, done_d;
  logic            wrap_q, wrap_d;
  logic [8:0]      birth_q, birth_d;
  logic [8:0]      survive_q, survive_d;

  // Bank storage has no reset; a reseed always follows reset.
  logic [N-1:0]    bank0_q, bank1_q;

  logic [N-1:0]    front_bits;
  logic            wr_en, wr_data, swap, start;
  logic [1:0]      dx, dy;
  logic [LOG_W:0]  nx;
  logic [LOG_H:0]  ny;
  logic            nbr_bit, new_cell;

  assign front_bits  = front_q ? bank1_q : bank0_q;
  assign bus.rd_cell = front_bits[{bus.rd_y, bus.rd_x}];
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.generation = gen_q;

  // Neighbour offset for the current accumulate phase (2'b11 = -1).
  always_comb begin
    dx = 2'b00;
    dy = 2'b00;
    case (phase_q[2:0])
      3'd0: begin dx = 2'b11; dy = 2'b01; end
      3'd1: begin dx = 2'b00; dy = 2'b01; end
      3'd2: begin dx = 2'b01; dy = 2'b01; end
      3'd3: begin dx = 2'b11; dy = 2'b00; end
      3'd4: begin dx = 2'b01; dy = 2'b00; end
      3'd5: begin dx = 2'b11; dy = 2'b11; end
      3'd6: begin dx = 2'b00; dy = 2'b11; end
      default: begin dx = 2'b01; dy = 2'b11; end
    endcase
  end

  // One guard bit catches both underflow (all ones) and overflow (== size);
  // wrap mode simply drops it.
  assign nx = {1'b0, idx_q[LOG_W-1:0]} + {{(LOG_W-1){dx[1]}}, dx};
  assign ny = {1'b0, idx_q[IW-1:LOG_W]} + {{(LOG_H-1){dy[1]}}, dy};
  assign nbr_bit  = (wrap_q | ~(nx[LOG_W] | ny[LOG_H])) &
                    front_bits[{ny[LOG_H-1:0], nx[LOG_W-1:0]}];
  assign new_cell = front_bits[idx_q] ? survive_q[cnt_q] : birth_q[cnt_q];

  // Next-state, write-port and swap decisions.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    gen_d       = gen_q;
    seed_flag_d = seed_flag_q;
    done_d      = 1'b0;
    wrap_d      = wrap_q;
    birth_d     = birth_q;
    survive_d   = survive_q;
    wr_en       = 1'b0;
    wr_data     = 1'b0;
    swap        = 1'b0;
    start       = 1'b0;
    case (state_q)
      SEED: begin
        wr_en   = 1'b1;
        wr_data = lfsr_q[0];
        idx_d   = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = WAIT_SYNC;
          swap    = bus.frame_sync;
        end
      end
      IDLE: begin
        if (bus.seed_req) begin
          start       = 1'b1;
          state_d     = SEED;
          idx_d       = '0;
          seed_flag_d = 1'b1;
        end else if (bus.step_req) begin
          start       = 1'b1;
          state_d     = STEP;
          idx_d       = '0;
          phase_d     = 4'd0;
          cnt_d       = 4'd0;
          seed_flag_d = 1'b0;
          wrap_d      = bus.wrap_en;
          birth_d     = bus.birth_mask;
          survive_d   = bus.survive_mask;
        end
      end
      STEP: begin
        if (phase_q == 4'd8) begin
          wr_en   = 1'b1;
          wr_data = new_cell;
          cnt_d   = 4'd0;
          phase_d = 4'd0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == '1) begin
            state_d = WAIT_SYNC;
            swap    = bus.frame_sync;
          end
        end else begin
          cnt_d   = cnt_q + {3'b000, nbr_bit};
          phase_d = phase_q + 4'd1;
        end
      end
      WAIT_SYNC: begin
        swap = bus.frame_sync;
      end
    endcase
    if (swap) begin
      front_d = ~front_q;
      state_d = IDLE;
      done_d  = 1'b1;
      gen_d   = seed_flag_q ? 16'd0 : gen_q + 16'd1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEED;
      front_q     <= 1'b0;
      idx_q       <= '0;
      phase_q     <= 4'd0;
      cnt_q       <= 4'd0;
      lfsr_q      <= LFSR_SEED;
      gen_q       <= 16'd0;
      seed_flag_q <= 1'b1;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      birth_q     <= 9'd0;
      survive_q   <= 9'd0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      gen_q       <= gen_d;
      seed_flag_q <= seed_flag_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      birth_q     <= birth_d;
      survive_q   <= survive_d;
    end
  end

  // Engine writes always target the back bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (front_q) bank0_q[idx_q] <= wr_data;
      else         bank1_q[idx_q] <= wr_data;
    end
  end

`ifdef LIFE_POPCOUNT_EN
  logic [IW:0] acc_q, acc_d, pop_q, pop_d;

  // Count cells as they are written; publish the total with the swap.
  always_comb begin
    acc_d = acc_q;
    if (start)      acc_d = '0;
    else if (wr_en) acc_d = acc_q + (IW+1)'(wr_data);
    pop_d = swap ? acc_d : pop_q;
  end

  // Population counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      pop_q <= '0;
    end else begin
      acc_q <= acc_d;
      pop_q <= pop_d;
    end
  end

  assign bus.pop_count = pop_q;
`else
  assign bus.pop_count = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_engine
//  Description : Scoreboard bench for life_engine on an 8x8 board. Expected
//                boards come from a reference LFSR and a Life model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_engine;
  localparam int LOG_W = 3;
  localparam int LOG_H = 3;
  localparam int W = 1 << LOG_W;
  localparam int H = 1 << LOG_H;
  localparam int N = W * H;
  localparam logic [15:0] SEED_VAL = 16'hACE1;
  localparam logic [8:0] B3   = 9'b000001000;
  localparam logic [8:0] S23  = 9'b000001100;
  localparam logic [8:0] HL_B = 9'b001001000;
  localparam logic [8:0] HL_S = 9'b000001100;
`ifdef LIFE_POPCOUNT_EN
  localparam bit POP_EN = 1'b1;
`else
  localparam bit POP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] board;
    logic [15:0]  gen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  life_engine_if #(.LOG_W(LOG_W), .LOG_H(LOG_H)) bus ();
  life_engine #(.LOG_W(LOG_W), .LOG_H(LOG_H), .LFSR_SEED(SEED_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  exp_t         sb[$];
  logic [N-1:0] model_board;
  logic [15:0]  model_gen;
  logic [N-1:0] shown;
  logic [15:0]  m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [N-1:0] seed_board(input logic [15:0] s0);
    logic [15:0]  s = s0;
    logic [N-1:0] b;
    for (int k = 0; k < N; k++) begin
      b[k] = s[0];
      s = lfsr_next(s);
    end
    return b;
  endfunction

  function automatic logic [N-1:0] next_gen(input logic [N-1:0] b,
                                            input logic [8:0] bm, input logic [8:0] sm,
                                            input logic wrap);
    logic [N-1:0] r;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int c = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int xx = x + dx;
            int yy = y + dy;
            if (dx == 0 && dy == 0) continue;
            if (wrap) begin
              xx = (xx + W) % W;
              yy = (yy + H) % H;
              c += int'(b[yy*W + xx]);
            end else if (xx >= 0 && xx < W && yy >= 0 && yy < H) begin
              c += int'(b[yy*W + xx]);
            end
          end
        end
        r[y*W + x] = b[y*W + x] ? sm[c] : bm[c];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_pop(input logic [N-1:0] b);
    return POP_EN ? 64'($countones(b)) : 64'd0;
  endfunction

  // Free-running reference LFSR, restarted by reset like the engine's.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED_VAL;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(output logic [N-1:0] b);
    for (int i = 0; i < N; i++) begin
      bus.rd_x = LOG_W'(i);
      bus.rd_y = LOG_H'(i >> LOG_W);
      #1;
      b[i] = bus.rd_cell;
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (bus.busy && n < 20000) begin
      n++;
      tick();
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.board = model_board;
    e.gen   = model_gen;
    sb.push_back(e);
  endtask

  task automatic issue_step(input logic [8:0] bm, input logic [8:0] sm, input logic w);
    bus.birth_mask   = bm;
    bus.survive_mask = sm;
    bus.wrap_en      = w;
    model_board = next_gen(model_board, bm, sm, w);
    model_gen   = model_gen + 16'd1;
    push_exp();
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
  endtask

  // Wait for the swap, pop the oldest expectation and compare.
  task automatic check_swap(input string tag);
    int           n = 0;
    exp_t         e;
    logic [N-1:0] got;
    while (!bus.done && n < 2000) begin
      tick();
      n++;
    end
    check_eq({tag, "_done"}, 64'(bus.done), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({tag, "_gen"}, 64'(bus.generation), 64'(e.gen));
      check_eq({tag, "_pop"}, 64'(bus.pop_count), exp_pop(e.board));
      tick();
      check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      scan(got);
      check_eq({tag, "_board"}, 64'(got), 64'(e.board));
      shown = e.board;
    end
  endtask

  // Test sequence.
  initial begin
    int           n;
    bit           seen;
    logic [N-1:0] got;
    bus.step_req = 1'b0;
    bus.seed_req = 1'b0;
    bus.birth_mask = B3;
    bus.survive_mask = S23;
    bus.wrap_en = 1'b1;
    bus.frame_sync = 1'b0;
    bus.rd_x = '0;
    bus.rd_y = '0;
    shown = '0;
    repeat (3) tick();
    check_eq("rst_busy", 64'(bus.busy), 64'd1);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_gen", 64'(bus.generation), 64'd0);
    check_eq("rst_pop", 64'(bus.pop_count), 64'd0);

    // Boot seed with frame_sync low: must hold in WAIT_SYNC.
    rst_n = 1'b1;
    model_board = seed_board(SEED_VAL);
    model_gen = 16'd0;
    push_exp();
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check_eq("seed_no_done", 64'(seen), 64'd0);
    check_eq("seed_busy", 64'(bus.busy), 64'd1);
    bus.frame_sync = 1'b1;
    check_swap("seed");

    // Several rules and both edge modes.
    issue_step(B3, S23, 1'b1);
    busy_len(n);
    check_eq("step_busy_len", 64'(n), 64'(9*N));
    check_swap("life_wrap");
    issue_step(B3, S23, 1'b0);
    busy_len(n);
    check_swap("life_dead");
    issue_step(HL_B, HL_S, 1'b1);
    busy_len(n);
    check_swap("highlife");
    issue_step(9'b010101010, 9'b101010101, 1'b0);
    busy_len(n);
    check_swap("odd_even");

    // Requests and rule changes while busy are ignored.
    issue_step(B3, S23, 1'b1);
    repeat (50) tick();
    bus.birth_mask = 9'h1FF;
    bus.survive_mask = 9'h000;
    bus.wrap_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.step_req = 1'b1;
      tick();
      bus.step_req = 1'b0;
      repeat (20) tick();
    end
    bus.seed_req = 1'b1;
    tick();
    bus.seed_req = 1'b0;
    check_swap("ignore");
    repeat (20) tick();
    check_eq("no_queued", 64'(bus.busy), 64'd0);
    check_eq("gen_hold", 64'(bus.generation), 64'(model_gen));

    // frame_sync low long after compute: display keeps the old bank.
    bus.frame_sync = 1'b0;
    issue_step(B3, S23, 1'b0);
    seen = 1'b0;
    repeat (9*N + 1000) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check_eq("hold_no_done", 64'(seen), 64'd0);
    check_eq("hold_busy", 64'(bus.busy), 64'd1);
    scan(got);
    check_eq("hold_board", 64'(got), 64'(shown));
    bus.frame_sync = 1'b1;
    check_swap("hold");

    // seed_req wins over step_req in the same cycle.
    bus.seed_req = 1'b1;
    bus.step_req = 1'b1;
    tick();
    bus.seed_req = 1'b0;
    bus.step_req = 1'b0;
    model_board = seed_board(m_lfsr);
    model_gen = 16'd0;
    push_exp();
    busy_len(n);
    check_eq("reseed_busy_len", 64'(n), 64'(N));
    check_swap("reseed");
    issue_step(B3, S23, 1'b1);
    busy_len(n);
    check_swap("post_seed");

    // Reset in the middle of a step.
    issue_step(B3, S23, 1'b1);
    repeat (100) tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd1);
    check_eq("mid_rst_gen", 64'(bus.generation), 64'd0);
    check_eq("mid_rst_done", 64'(bus.done), 64'd0);
    check_eq("mid_rst_pop", 64'(bus.pop_count), 64'd0);
    tick();
    rst_n = 1'b1;
    model_board = seed_board(SEED_VAL);
    model_gen = 16'd0;
    push_exp();
    busy_len(n);
    check_eq("rst_seed_busy_len", 64'(n), 64'(N));
    check_swap("rst_seed");
    issue_step(B3, S23, 1'b0);
    busy_len(n);
    check_swap("rst_step");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
